// File: rtl/parallel_to_serial.sv
// rtl/parallel_to_serial.sv - word-to-bit serializer, LSB first, one-entry hold buffer for gap-free streaming
module parallel_to_serial #(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             parallel_valid,
    output logic             parallel_ready,
    input  logic [width-1:0] parallel_data,
    output logic             serial_valid,
    output logic             serial_data,
    output logic             busy
);
    localparam int CW = $clog2(width);
    localparam logic [CW-1:0] LAST = CW'(width - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [width-1:0] shift_q, shift_d;
    logic [width-1:0] hold_q, hold_d;
    logic             hold_valid_q, hold_valid_d;
    logic             accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            count_q      <= '0;
            shift_q      <= '0;
            hold_q       <= '0;
            hold_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            shift_q      <= shift_d;
            hold_q       <= hold_d;
            hold_valid_q <= hold_valid_d;
        end
    end

    always_comb begin
        accept       = parallel_valid && !hold_valid_q;
        state_d      = state_q;
        count_d      = count_q;
        shift_d      = shift_q;
        hold_d       = hold_q;
        hold_valid_d = hold_valid_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d = parallel_data;
                    count_d = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (count_q == LAST) begin
                    // The held word has priority; ready is low while it is held, so no accept can collide
                    count_d = '0;
                    if (hold_valid_q) begin
                        shift_d      = hold_q;
                        hold_valid_d = 1'b0;
                    end else if (accept) begin
                        shift_d = parallel_data;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    shift_d = shift_q >> 1;
                    count_d = count_q + 1'b1;
                    if (accept) begin
                        hold_d       = parallel_data;
                        hold_valid_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign parallel_ready = !hold_valid_q;
    assign serial_valid   = (state_q == SHIFT);
    assign serial_data    = serial_valid & shift_q[0];
    assign busy           = serial_valid | hold_valid_q;

endmodule
